// File: rtl/fight_pkg.sv
// fight_pkg: shared encodings for the match controller and player instances
package fight_pkg;
   typedef enum logic [2:0] {
      G_MENU      = 3'd0,
      G_COUNTDOWN = 3'd1,
      G_FIGHT     = 3'd2,
      G_ROUNDOVER = 3'd3,
      G_GAMEOVER  = 3'd4
   } gamestate_e;
   localparam logic [3:0] S_IDLE           = 4'd0;
   localparam logic [3:0] S_MOVEFORWARDS   = 4'd1;
   localparam logic [3:0] S_MOVEBACKWARDS  = 4'd2;
   localparam logic [3:0] S_B_ATTACK_START = 4'd3;
   localparam logic [3:0] S_B_ATTACK_END   = 4'd4;
   localparam logic [3:0] S_D_ATTACK_START = 4'd5;
   localparam logic [3:0] S_D_ATTACK_MID   = 4'd6;
   localparam logic [3:0] S_D_ATTACK_END   = 4'd7;
   localparam logic [3:0] S_HITSTUN        = 4'd8;
   localparam logic [3:0] S_BLOCK          = 4'd9;
   localparam logic [3:0] S_BLOCKSTUN      = 4'd10;
   localparam logic [1:0] notHit           = 2'b00;
   localparam logic [1:0] hitByBasic       = 2'b01;
   localparam logic [1:0] hitByDirectional = 2'b10;
   localparam int BOX_W     = 40;
   localparam int BASIC_LSB = 80;
   localparam int DIR_LSB   = 40;
   localparam int MAIN_LSB  = 0;
endpackage

// File: rtl/fight_director_if.sv
// fight_director_if: per-frame player inputs and match results exchanged with the director
interface fight_director_if;
   import fight_pkg::*;
   logic         frame_tick;
   logic         start;
   logic [3:0]   p1_state, p2_state;
   logic [119:0] p1_boxes, p2_boxes;
   logic [2:0]   gamestate;
   logic [1:0]   p1_hitFlag, p2_hitFlag;
   logic [2:0]   p1_health, p2_health;
   logic [2:0]   p1_block, p2_block;
   logic [1:0]   p1_wins, p2_wins;
   logic [1:0]   winner;
   modport master (
      output frame_tick, start, p1_state, p2_state, p1_boxes, p2_boxes,
      input  gamestate, p1_hitFlag, p2_hitFlag, p1_health, p2_health,
             p1_block, p2_block, p1_wins, p2_wins, winner
   );
   modport slave (
      input  frame_tick, start, p1_state, p2_state, p1_boxes, p2_boxes,
      output gamestate, p1_hitFlag, p2_hitFlag, p1_health, p2_health,
             p1_block, p2_block, p1_wins, p2_wins, winner
   );
endinterface

// File: rtl/box_overlap.sv
// box_overlap: inclusive intersect of two packed {x1,x2,y1,y2} rectangles
module box_overlap (
   input  logic [39:0] a_i,
   input  logic [39:0] b_i,
   output logic        hit_o
);
   assign hit_o = a_i[39:30] <= b_i[29:20] && b_i[39:30] <= a_i[29:20] &&
                  a_i[19:10] <= b_i[9:0]   && b_i[19:10] <= a_i[9:0];
endmodule

// File: rtl/fight_director.sv
// fight_director: gamestate sequencing and per-frame combat resolution for both players
module fight_director
   import fight_pkg::*;
#(
   parameter logic [2:0] HEALTH_INIT     = 3'd3,
   parameter logic [2:0] BLOCK_INIT      = 3'd3,
   parameter int         COUNTDOWN_TICKS = 180,
   parameter int         ROUNDOVER_TICKS = 120,
   parameter logic [1:0] WINS_NEEDED     = 2'd2,
   parameter logic [2:0] DIR_DAMAGE      = 3'd2
) (
   input logic            clk,
   input logic            rst,
   fight_director_if.slave bus
);
   gamestate_e       gs_q;
   logic [7:0]       cnt_q;
   logic             start_q;
   logic [1:0][2:0]  health_q, health_d, block_q, block_d, dmg;
   logic [1:0][1:0]  wins_q, flag_q, flag_d;
   logic [1:0]       winner_q, done_q, done_d, hit_d, blk, ov_b, ov_d;
   logic [1:0][3:0]  st;
   logic [1:0][119:0] bx;
   logic             live, start_rise;
   assign st = {bus.p2_state, bus.p1_state};
   assign bx = {bus.p2_boxes, bus.p1_boxes};
   assign live = |health_q[0] && |health_q[1];
   assign start_rise = bus.start & ~start_q;
   for (genvar a = 0; a < 2; a++) begin : g_ov
      box_overlap u_basic (.a_i(bx[a][BASIC_LSB +: BOX_W]), .b_i(bx[1-a][MAIN_LSB +: BOX_W]), .hit_o(ov_b[a]));
      box_overlap u_dir   (.a_i(bx[a][DIR_LSB +: BOX_W]),   .b_i(bx[1-a][MAIN_LSB +: BOX_W]), .hit_o(ov_d[a]));
   end
   // each attacker (index a) resolves against the opposite victim independently, so trades fall out naturally
   always_comb begin
      health_d = health_q;
      block_d = block_q;
      flag_d = '0;
      done_d = '0;
      hit_d = '0;
      blk = '0;
      dmg = '0;
      for (int a = 0; a < 2; a++) begin
         hit_d[a] = gs_q == G_FIGHT && bus.frame_tick && live && !done_q[a] &&
                    ((st[a] == S_B_ATTACK_END && ov_b[a]) || (st[a] == S_D_ATTACK_END && ov_d[a]));
         done_d[a] = (st[a] == S_B_ATTACK_END || st[a] == S_D_ATTACK_END) && (done_q[a] || hit_d[a]);
         blk[1-a] = st[1-a] == S_MOVEBACKWARDS && block_q[1-a] != 3'd0;
         dmg[a] = st[a] == S_D_ATTACK_END ? DIR_DAMAGE : 3'd1;
         flag_d[1-a] = hit_d[a] ? (st[a] == S_D_ATTACK_END ? hitByDirectional : hitByBasic) : notHit;
         block_d[1-a] = hit_d[a] && blk[1-a] ? block_q[1-a] - 3'd1 : block_q[1-a];
         health_d[1-a] = hit_d[a] && !blk[1-a] ?
                         (health_q[1-a] > dmg[a] ? health_q[1-a] - dmg[a] : 3'd0) : health_q[1-a];
      end
   end
   // match FSM; hitFlags default to 00 every cycle so they only pulse after an evaluating tick
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gs_q <= G_MENU;
         cnt_q <= '0;
         start_q <= 1'b0;
         health_q <= {2{HEALTH_INIT}};
         block_q <= {2{BLOCK_INIT}};
         wins_q <= '0;
         winner_q <= '0;
         flag_q <= '0;
         done_q <= '0;
      end else begin
         start_q <= bus.start;
         done_q <= done_d;
         flag_q <= '0;
         case (gs_q)
            G_MENU: begin
               health_q <= {2{HEALTH_INIT}};
               block_q <= {2{BLOCK_INIT}};
               wins_q <= '0;
               winner_q <= '0;
               cnt_q <= '0;
               if (start_rise) gs_q <= G_COUNTDOWN;
            end
            G_COUNTDOWN: if (bus.frame_tick) begin
               cnt_q <= cnt_q == 8'(COUNTDOWN_TICKS - 1) ? 8'd0 : cnt_q + 8'd1;
               if (cnt_q == 8'(COUNTDOWN_TICKS - 1)) gs_q <= G_FIGHT;
            end
            G_FIGHT: if (!live) begin
               gs_q <= G_ROUNDOVER;
               winner_q <= {health_q[0] == 3'd0, health_q[1] == 3'd0};
               for (int s = 0; s < 2; s++)
                  if (health_q[1-s] == 3'd0 && health_q[s] != 3'd0 && wins_q[s] != 2'd3)
                     wins_q[s] <= wins_q[s] + 2'd1;
            end else begin
               health_q <= health_d;
               block_q <= block_d;
               flag_q <= flag_d;
            end
            G_ROUNDOVER: if (bus.frame_tick) begin
               cnt_q <= cnt_q == 8'(ROUNDOVER_TICKS - 1) ? 8'd0 : cnt_q + 8'd1;
               if (cnt_q == 8'(ROUNDOVER_TICKS - 1)) begin
                  if (wins_q[0] == WINS_NEEDED || wins_q[1] == WINS_NEEDED) gs_q <= G_GAMEOVER;
                  else begin
                     gs_q <= G_COUNTDOWN;
                     health_q <= {2{HEALTH_INIT}};
                     block_q <= {2{BLOCK_INIT}};
                     winner_q <= '0;
                     done_q <= '0;
                  end
               end
            end
            G_GAMEOVER: if (start_rise) gs_q <= G_MENU;
            default: gs_q <= G_MENU;
         endcase
      end
   end
   assign bus.gamestate  = gs_q;
   assign bus.p1_hitFlag = flag_q[0];
   assign bus.p2_hitFlag = flag_q[1];
   assign bus.p1_health  = health_q[0];
   assign bus.p2_health  = health_q[1];
   assign bus.p1_block   = block_q[0];
   assign bus.p2_block   = block_q[1];
   assign bus.p1_wins    = wins_q[0];
   assign bus.p2_wins    = wins_q[1];
   assign bus.winner     = winner_q;
endmodule

// File: tb/tb_fight_director.sv
// tb_fight_director: vector table, hand-built match sequences and a randomized run against a rules model
module tb_fight_director;
   import fight_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;
   fight_director_if bus();
   fight_director dut (.clk(clk), .rst(rst), .bus(bus));

   int n_tests = 0;
   int n_fail = 0;
   localparam logic [24:0] RST_VEC = {3'd0, 2'd0, 2'd0, 3'd3, 3'd3, 3'd3, 3'd3, 2'd0, 2'd0, 2'd0};

   typedef struct {
      logic [3:0]   s1, s2;
      logic [119:0] bx1, bx2;
      logic [1:0]   f1, f2;
      logic [2:0]   h1, h2, b1, b2;
   } vec_t;
   vec_t tv[7];

   // rules model: whole-match state kept as plain integers
   int m_gs, m_cnt, m_win;
   int m_h[2], m_b[2], m_w[2], m_f[2];
   bit m_done[2];
   bit m_sprev;

   logic [119:0] p1_hit_bx, p1_miss_bx, p1_touch_bx, p1_vmiss_bx, p2_hit_bx, p2_miss_bx;
   int st_pool[10] = '{0, 2, 2, 4, 4, 7, 7, 1, 10, 5};

   function automatic logic [39:0] mk(int x1, int x2, int y1, int y2);
      return {10'(x1), 10'(x2), 10'(y1), 10'(y2)};
   endfunction

   function automatic logic [39:0] rbox();
      int x1, y1;
      x1 = $urandom_range(0, 300);
      y1 = $urandom_range(0, 300);
      return mk(x1, x1 + $urandom_range(0, 80), y1, y1 + $urandom_range(0, 80));
   endfunction

   function automatic bit rect_hit(logic [39:0] a, logic [39:0] b);
      int ax1, ax2, ay1, ay2, bx1, bx2, by1, by2;
      ax1 = int'(a[39:30]); ax2 = int'(a[29:20]); ay1 = int'(a[19:10]); ay2 = int'(a[9:0]);
      bx1 = int'(b[39:30]); bx2 = int'(b[29:20]); by1 = int'(b[19:10]); by2 = int'(b[9:0]);
      return ax1 <= bx2 && bx1 <= ax2 && ay1 <= by2 && by1 <= ay2;
   endfunction

   task automatic model_reset();
      m_gs = 0; m_cnt = 0; m_win = 0;
      m_h = '{3, 3}; m_b = '{3, 3}; m_w = '{0, 0}; m_f = '{0, 0};
      m_done = '{0, 0};
      m_sprev = 0;
   endtask

   task automatic model_clock();
      int st[2];
      logic [119:0] bx[2];
      int nh[2], nb[2], nf[2];
      bit nd[2];
      int kind, v;
      bit rise;
      if (!rst) begin
         model_reset();
         return;
      end
      st[0] = int'(bus.p1_state); st[1] = int'(bus.p2_state);
      bx[0] = bus.p1_boxes; bx[1] = bus.p2_boxes;
      rise = bus.start && !m_sprev;
      m_sprev = bus.start;
      nh = m_h; nb = m_b; nf = '{0, 0}; nd = m_done;
      for (int a = 0; a < 2; a++) if (st[a] != 4 && st[a] != 7) nd[a] = 0;
      case (m_gs)
         0: begin
            nh = '{3, 3}; nb = '{3, 3}; m_w = '{0, 0}; m_win = 0; m_cnt = 0;
            if (rise) m_gs = 1;
         end
         1: if (bus.frame_tick) begin
            if (m_cnt == 179) begin m_cnt = 0; m_gs = 2; end
            else m_cnt++;
         end
         2: if (m_h[0] == 0 || m_h[1] == 0) begin
            m_win = (m_h[1] == 0 ? 1 : 0) + (m_h[0] == 0 ? 2 : 0);
            if (m_win == 1 && m_w[0] < 3) m_w[0]++;
            if (m_win == 2 && m_w[1] < 3) m_w[1]++;
            m_gs = 3;
         end else if (bus.frame_tick) begin
            for (int a = 0; a < 2; a++) begin
               v = 1 - a;
               kind = st[a] == 4 ? 1 : st[a] == 7 ? 2 : 0;
               if (kind != 0 && !m_done[a] &&
                   rect_hit(kind == 1 ? bx[a][119:80] : bx[a][79:40], bx[v][39:0])) begin
                  nf[v] = kind;
                  nd[a] = 1;
                  if (st[v] == 2 && m_b[v] > 0) nb[v] = m_b[v] - 1;
                  else nh[v] = m_h[v] > kind ? m_h[v] - kind : 0;
               end
            end
         end
         3: if (bus.frame_tick) begin
            if (m_cnt == 119) begin
               m_cnt = 0;
               if (m_w[0] == 2 || m_w[1] == 2) m_gs = 4;
               else begin
                  m_gs = 1; nh = '{3, 3}; nb = '{3, 3}; m_win = 0; nd = '{0, 0};
               end
            end else m_cnt++;
         end
         4: if (rise) m_gs = 0;
         default: m_gs = 0;
      endcase
      m_h = nh; m_b = nb; m_f = nf; m_done = nd;
   endtask

   function automatic logic [24:0] mexp();
      return {3'(m_gs), 2'(m_f[0]), 2'(m_f[1]), 3'(m_h[0]), 3'(m_h[1]), 3'(m_b[0]), 3'(m_b[1]),
              2'(m_w[0]), 2'(m_w[1]), 2'(m_win)};
   endfunction

   function automatic logic [24:0] dut_out();
      return {bus.gamestate, bus.p1_hitFlag, bus.p2_hitFlag, bus.p1_health, bus.p2_health,
              bus.p1_block, bus.p2_block, bus.p1_wins, bus.p2_wins, bus.winner};
   endfunction

   task automatic chk(string name, int act, int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      model_clock();
      @(posedge clk);
      #1;
      chk("model", int'(dut_out()), int'(mexp()));
   endtask

   task automatic set_in(int s1, int s2, logic [119:0] b1, logic [119:0] b2);
      bus.p1_state = 4'(s1); bus.p2_state = 4'(s2);
      bus.p1_boxes = b1; bus.p2_boxes = b2;
   endtask

   task automatic hit(int s1, int s2, logic [119:0] b1, logic [119:0] b2);
      set_in(s1, s2, b1, b2);
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
   endtask

   task automatic idle();
      set_in(0, 0, bus.p1_boxes, bus.p2_boxes);
      step();
   endtask

   task automatic ticks(int n);
      for (int i = 0; i < n; i++) begin
         bus.frame_tick = 1'b1; step();
         bus.frame_tick = 1'b0; step();
      end
   endtask

   task automatic press();
      bus.start = 1'b1; step();
      bus.start = 1'b0; step();
   endtask

   initial begin
      p1_hit_bx   = {mk(140, 210, 120, 140), mk(140, 260, 150, 160), mk(100, 150, 100, 200)};
      p1_miss_bx  = {mk(140, 199, 120, 140), mk(140, 199, 150, 160), mk(100, 150, 100, 200)};
      p1_touch_bx = {mk(140, 200, 120, 140), mk(140, 199, 150, 160), mk(100, 150, 100, 200)};
      p1_vmiss_bx = {mk(140, 210, 80, 99),   mk(140, 260, 150, 160), mk(100, 150, 100, 200)};
      p2_hit_bx   = {mk(90, 210, 120, 140),  mk(90, 210, 150, 160),  mk(200, 250, 100, 200)};
      p2_miss_bx  = {mk(151, 210, 120, 140), mk(151, 210, 150, 160), mk(200, 250, 100, 200)};
      tv[0] = '{4'd4, 4'd4, p1_hit_bx,   p2_hit_bx,  2'd1, 2'd1, 3'd2, 3'd1, 3'd3, 3'd3};
      tv[1] = '{4'd4, 4'd4, p1_miss_bx,  p2_miss_bx, 2'd0, 2'd0, 3'd2, 3'd1, 3'd3, 3'd3};
      tv[2] = '{4'd2, 4'd7, p1_miss_bx,  p2_hit_bx,  2'd2, 2'd0, 3'd2, 3'd1, 3'd2, 3'd3};
      tv[3] = '{4'd7, 4'd2, p1_hit_bx,   p2_miss_bx, 2'd0, 2'd2, 3'd2, 3'd1, 3'd2, 3'd2};
      tv[4] = '{4'd4, 4'd2, p1_touch_bx, p2_miss_bx, 2'd0, 2'd1, 3'd2, 3'd1, 3'd2, 3'd1};
      tv[5] = '{4'd5, 4'd6, p1_hit_bx,   p2_hit_bx,  2'd0, 2'd0, 3'd2, 3'd1, 3'd2, 3'd1};
      tv[6] = '{4'd4, 4'd0, p1_vmiss_bx, p2_miss_bx, 2'd0, 2'd0, 3'd2, 3'd1, 3'd2, 3'd1};
      bus.start = 1'b0; bus.frame_tick = 1'b0;
      set_in(0, 0, p1_miss_bx, p2_miss_bx);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset values", int'(dut_out()), int'(RST_VEC));
      rst = 1'b1;
      bus.start = 1'b1;
      repeat (10) step();
      chk("countdown entry", int'(bus.gamestate), 1);
      bus.start = 1'b0;
      step();
      ticks(179);
      chk("still countdown at 179", int'(bus.gamestate), 1);
      ticks(1);
      chk("fight after 180", int'(bus.gamestate), 2);
      hit(4, 0, p1_hit_bx, p2_miss_bx);
      chk("basic p2 flag", int'(bus.p2_hitFlag), 1);
      chk("basic p2 health", int'(bus.p2_health), 2);
      step();
      chk("flag pulse ends", int'(bus.p2_hitFlag), 0);
      repeat (3) begin
         hit(4, 0, p1_hit_bx, p2_miss_bx);
         chk("one hit per attack health", int'(bus.p2_health), 2);
         chk("one hit per attack flag", int'(bus.p2_hitFlag), 0);
      end
      idle();
      for (int i = 0; i < 7; i++) begin
         hit(tv[i].s1, tv[i].s2, tv[i].bx1, tv[i].bx2);
         chk($sformatf("vector %0d", i),
             int'({bus.p1_hitFlag, bus.p2_hitFlag, bus.p1_health, bus.p2_health, bus.p1_block, bus.p2_block}),
             int'({tv[i].f1, tv[i].f2, tv[i].h1, tv[i].h2, tv[i].b1, tv[i].b2}));
         idle();
         chk($sformatf("vector %0d flags clear", i), int'({bus.p1_hitFlag, bus.p2_hitFlag}), 0);
      end
      hit(4, 0, p1_hit_bx, p2_miss_bx);
      chk("ko health", int'(bus.p2_health), 0);
      idle();
      chk("round1 over", int'({bus.gamestate, bus.winner, bus.p1_wins, bus.p2_wins}), int'({3'd3, 2'd1, 2'd1, 2'd0}));
      ticks(119);
      chk("roundover hold", int'(bus.gamestate), 3);
      ticks(1);
      chk("reload", int'({bus.gamestate, bus.p1_health, bus.p2_health, bus.p1_block, bus.p2_block, bus.winner}),
          int'({3'd1, 3'd3, 3'd3, 3'd3, 3'd3, 2'd0}));
      ticks(180);
      chk("round2 fight", int'(bus.gamestate), 2);
      repeat (3) begin
         hit(2, 7, p1_miss_bx, p2_hit_bx);
         chk("dir blocked flag", int'(bus.p1_hitFlag), 2);
         idle();
      end
      chk("blocks spent", int'({bus.p1_block, bus.p1_health}), int'({3'd0, 3'd3}));
      hit(2, 7, p1_miss_bx, p2_hit_bx);
      chk("dir unblocked", int'({bus.p1_hitFlag, bus.p1_health, bus.p1_block}), int'({2'd2, 3'd1, 3'd0}));
      idle();
      repeat (2) begin hit(4, 0, p1_hit_bx, p2_miss_bx); idle(); end
      chk("p2 at 1", int'(bus.p2_health), 1);
      hit(4, 4, p1_hit_bx, p2_hit_bx);
      chk("trade", int'({bus.p1_hitFlag, bus.p2_hitFlag, bus.p1_health, bus.p2_health}), int'({2'd1, 2'd1, 3'd0, 3'd0}));
      idle();
      chk("draw", int'({bus.gamestate, bus.winner, bus.p1_wins, bus.p2_wins}), int'({3'd3, 2'd3, 2'd1, 2'd0}));
      ticks(120);
      ticks(180);
      chk("round3 fight", int'(bus.gamestate), 2);
      repeat (3) begin hit(4, 0, p1_hit_bx, p2_miss_bx); idle(); end
      chk("round3 over", int'({bus.gamestate, bus.winner, bus.p1_wins}), int'({3'd3, 2'd1, 2'd2}));
      ticks(119);
      chk("round3 hold", int'(bus.gamestate), 3);
      ticks(1);
      chk("gameover", int'({bus.gamestate, bus.winner, bus.p1_wins, bus.p2_wins}), int'({3'd4, 2'd1, 2'd2, 2'd0}));
      repeat (5) step();
      chk("gameover hold", int'(bus.gamestate), 4);
      press();
      chk("back to menu", int'({bus.gamestate, bus.p1_wins, bus.winner}), 0);
      press();
      ticks(180);
      hit(0, 7, p1_miss_bx, p2_hit_bx);
      chk("pre-reset hit", int'({bus.gamestate, bus.p1_hitFlag, bus.p1_health}), int'({3'd2, 2'd2, 3'd1}));
      #3 rst = 1'b0;
      #1;
      chk("async reset", int'(dut_out()), int'(RST_VEC));
      model_reset();
      step();
      rst = 1'b1;
      for (int i = 0; i < 6000; i++) begin
         bus.frame_tick = 1'($urandom_range(0, 1));
         bus.start = $urandom_range(0, 99) == 0;
         set_in(st_pool[$urandom_range(0, 9)], st_pool[$urandom_range(0, 9)],
                {rbox(), rbox(), rbox()}, {rbox(), rbox(), rbox()});
         step();
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
